// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM states, owner
// encoding and the default outstanding-transaction timeout.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_e;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
// The last-grant register only moves when a grant is actually issued.
module mem_arb_rr
  import mem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en_i,
  input  logic   ifu_req_i,
  input  logic   lsu_req_i,
  output logic   gnt_vld_o,
  output owner_e gnt_owner_o
);

  owner_e last_q, last_d;

  always_comb begin
    gnt_vld_o   = en_i & (ifu_req_i | lsu_req_i);
    gnt_owner_o = OWNER_IFU;
    if (ifu_req_i && lsu_req_i) begin
      gnt_owner_o = (last_q == OWNER_IFU) ? OWNER_LSU : OWNER_IFU;
    end else if (lsu_req_i) begin
      gnt_owner_o = OWNER_LSU;
    end
    last_d = last_q;
    if (gnt_vld_o) begin
      last_d = gnt_owner_o;
    end
  end

  // Resetting to LSU makes the IFU win the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= OWNER_LSU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IFU fetches and LSU loads/stores onto a single downstream memory
// port with one outstanding transaction and a per-transaction timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ifu_req_valid,
  output logic               ifu_req_ready,
  input  logic [WIDTH-1:0]   ifu_addr,
  output logic               ifu_rsp_valid,
  output logic [WIDTH-1:0]   ifu_rsp_data,
  output logic               ifu_rsp_err,
  input  logic               lsu_req_valid,
  output logic               lsu_req_ready,
  input  logic [WIDTH-1:0]   lsu_addr,
  input  logic               lsu_we,
  input  logic [WIDTH-1:0]   lsu_wdata,
  input  logic [WIDTH/8-1:0] lsu_wmask,
  output logic               lsu_rsp_valid,
  output logic [WIDTH-1:0]   lsu_rsp_data,
  output logic               lsu_rsp_err,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [WIDTH-1:0]   mem_addr,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic [WIDTH/8-1:0] mem_wmask,
  input  logic               mem_rsp_valid,
  input  logic [WIDTH-1:0]   mem_rsp_data,
  input  logic               mem_rsp_err
);

  localparam int MW    = WIDTH / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [MW-1:0]      wmask_q, wmask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ifu_vld_q, ifu_vld_d, lsu_vld_q, lsu_vld_d;
  logic [WIDTH-1:0]   ifu_data_q, ifu_data_d, lsu_data_q, lsu_data_d;
  logic               ifu_err_q, ifu_err_d, lsu_err_q, lsu_err_d;

  logic               gnt_vld;
  owner_e             gnt_owner;
  logic               timeout_hit;
  logic               rsp_fire;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_err;

  mem_arb_rr u_rr (
    .clk         (clk),
    .rst         (rst),
    .en_i        (state_q == ST_IDLE),
    .ifu_req_i   (ifu_req_valid),
    .lsu_req_i   (lsu_req_valid),
    .gnt_vld_o   (gnt_vld),
    .gnt_owner_o (gnt_owner)
  );

  // The counter reaches TIMEOUT at the edge ending the cycle where this holds.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    cnt_d    = cnt_q;
    rsp_fire = 1'b0;
    rsp_data = '0;
    rsp_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          owner_d = gnt_owner;
          cnt_d   = '0;
          state_d = ST_REQ;
          if (gnt_owner == OWNER_IFU) begin
            addr_d  = ifu_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end else begin
            addr_d  = lsu_addr;
            we_d    = lsu_we;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wmask;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout_hit) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          state_d  = ST_IDLE;
        end else if (mem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A real response arriving on the timeout cycle takes precedence.
        if (mem_rsp_valid) begin
          rsp_fire = 1'b1;
          rsp_data = mem_rsp_data;
          rsp_err  = mem_rsp_err;
          state_d  = ST_IDLE;
        end else if (timeout_hit) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ifu_vld_d  = rsp_fire && (owner_q == OWNER_IFU);
    lsu_vld_d  = rsp_fire && (owner_q == OWNER_LSU);
    ifu_data_d = ifu_vld_d ? rsp_data : ifu_data_q;
    ifu_err_d  = ifu_vld_d ? rsp_err  : ifu_err_q;
    lsu_data_d = lsu_vld_d ? rsp_data : lsu_data_q;
    lsu_err_d  = lsu_vld_d ? rsp_err  : lsu_err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWNER_IFU;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      cnt_q      <= '0;
      ifu_vld_q  <= 1'b0;
      lsu_vld_q  <= 1'b0;
      ifu_data_q <= '0;
      ifu_err_q  <= 1'b0;
      lsu_data_q <= '0;
      lsu_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      cnt_q      <= cnt_d;
      ifu_vld_q  <= ifu_vld_d;
      lsu_vld_q  <= lsu_vld_d;
      ifu_data_q <= ifu_data_d;
      ifu_err_q  <= ifu_err_d;
      lsu_data_q <= lsu_data_d;
      lsu_err_q  <= lsu_err_d;
    end
  end

  assign ifu_req_ready = gnt_vld && (gnt_owner == OWNER_IFU);
  assign lsu_req_ready = gnt_vld && (gnt_owner == OWNER_LSU);
  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_addr      = addr_q;
  assign mem_we        = we_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign ifu_rsp_valid = ifu_vld_q;
  assign ifu_rsp_data  = ifu_data_q;
  assign ifu_rsp_err   = ifu_err_q;
  assign lsu_rsp_valid = lsu_vld_q;
  assign lsu_rsp_data  = lsu_data_q;
  assign lsu_rsp_err   = lsu_err_q;

endmodule
